mips_debug_loader: RTL and testbench

- Single-clock host-side loader/monitor for the pipelined MIPS32 core.
- Accepts a byte stream containing a program and writes it into instruction memory while holding the core in reset.
- Releases the core and waits for it to halt.
- Reads back the low register-file entries and streams them out as 32-bit words.
- Replaces hierarchical program preload and register display with synthesizable hardware.

---
 rtl/mips_dbg_pkg.sv | 24 ++
 rtl/mips_dbg_byte_packer.sv | 40 ++++
 rtl/mips_debug_loader.sv | 165 ++++++++++++++++
 tb/tb_mips_debug_loader.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_dbg_pkg.sv
`default_nettype none
// ============================================================================
// Module : mips_dbg_pkg
// Brief  : Shared widths and loader FSM state encodings for mips_debug_loader.
// Rev    : 1.0 - initial release
// ============================================================================
package mips_dbg_pkg;

    localparam int WORD_W  = 32;
    localparam int REG_AW  = 5;
    localparam int STATE_W = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LOAD     = 3'd1;
    localparam logic [2:0] START    = 3'd2;
    localparam logic [2:0] RUN      = 3'd3;
    localparam logic [2:0] DUMP_RD  = 3'd4;
    localparam logic [2:0] DUMP_CAP = 3'd5;
    localparam logic [2:0] DUMP_OUT = 3'd6;

endpackage
`default_nettype wire

// File: rtl/mips_dbg_byte_packer.sv
`default_nettype none
// ============================================================================
// Module : mips_dbg_byte_packer
// Brief  : Big-endian 8-to-32 assembler; o_word_done marks the 4th byte.
// Rev    : 1.0 - initial release
// ============================================================================
module mips_dbg_byte_packer
    import mips_dbg_pkg::*;
(
    input  logic              clk1,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_valid,
    input  logic [7:0]        i_byte,
    output logic              o_word_done,
    output logic [WORD_W-1:0] o_word
);

    logic [23:0] r_shift;
    logic [1:0]  r_byte_idx;

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_shift    <= '0;
            r_byte_idx <= '0;
        end else if (i_clear) begin
            r_shift    <= '0;
            r_byte_idx <= '0;
        end else if (i_valid) begin
            r_shift    <= {r_shift[15:0], i_byte};
            r_byte_idx <= r_byte_idx + 2'd1;
        end
    end

    // The completed word is presented combinationally alongside the 4th byte.
    assign o_word_done = i_valid && (r_byte_idx == 2'd3);
    assign o_word      = {r_shift, i_byte};

endmodule
`default_nettype wire

// File: rtl/mips_debug_loader.sv
`default_nettype none
// ============================================================================
// Module : mips_debug_loader
// Brief  : Loads a program into IMEM, runs the core to halt, dumps registers.
// Rev    : 1.0 - initial release
// ============================================================================
module mips_debug_loader
    import mips_dbg_pkg::*;
#(
    parameter int IMEM_AW     = 10,
    parameter int NUM_DUMP    = 6,
    parameter int RUN_TIMEOUT = 4096,
    parameter int TO_W        = 16
) (
    input  logic               clk1,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [WORD_W-1:0]  imem_wdata,
    output logic               core_reset,
    input  logic               core_halted,
    output logic [REG_AW-1:0]  reg_raddr,
    input  logic [WORD_W-1:0]  reg_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WORD_W-1:0]  out_data,
    output logic               busy,
    output logic               timeout
);

    localparam logic [TO_W-1:0]   c_to_last   = TO_W'(RUN_TIMEOUT - 1);
    localparam logic [REG_AW-1:0] c_dump_last = REG_AW'(NUM_DUMP - 1);

    state_t              r_state;
    logic [7:0]          r_count;
    logic [IMEM_AW-1:0]  r_widx;
    logic [TO_W-1:0]     r_to_cnt;
    logic [REG_AW-1:0]   r_didx;
    logic                r_core_reset;
    logic                r_imem_we;
    logic [IMEM_AW-1:0]  r_imem_addr;
    logic [WORD_W-1:0]   r_imem_wdata;
    logic [REG_AW-1:0]   r_reg_raddr;
    logic                r_out_valid;
    logic [WORD_W-1:0]   r_out_data;
    logic                r_timeout;

    logic                w_in_ready;
    logic                w_accept;
    logic                w_word_done;
    logic [WORD_W-1:0]   w_word;
    logic                w_last_word;

    assign w_in_ready  = (r_state == IDLE) || (r_state == LOAD);
    assign w_accept    = in_valid && w_in_ready;
    assign w_last_word = (r_widx == IMEM_AW'(r_count - 8'd1));

    mips_dbg_byte_packer u_packer (
        .clk1        (clk1),
        .rst         (rst),
        .i_clear     (w_accept && (r_state == IDLE)),
        .i_valid     (w_accept && (r_state == LOAD)),
        .i_byte      (in_data),
        .o_word_done (w_word_done),
        .o_word      (w_word)
    );

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_widx       <= '0;
            r_to_cnt     <= '0;
            r_didx       <= '0;
            r_core_reset <= 1'b1;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_reg_raddr  <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_imem_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept && (in_data != 8'd0)) begin
                        r_count   <= in_data;
                        r_widx    <= '0;
                        r_timeout <= 1'b0;
                        r_state   <= LOAD;
                    end
                end
                LOAD: begin
                    if (w_word_done) begin
                        r_imem_we    <= 1'b1;
                        r_imem_addr  <= r_widx;
                        r_imem_wdata <= w_word;
                        r_widx       <= r_widx + IMEM_AW'(1);
                        if (w_last_word) begin
                            r_state <= START;
                        end
                    end
                end
                START: begin
                    r_core_reset <= 1'b0;
                    r_to_cnt     <= '0;
                    r_state      <= RUN;
                end
                RUN: begin
                    // Halt takes priority over expiry in the same cycle.
                    if (core_halted || (r_to_cnt == c_to_last)) begin
                        r_timeout   <= !core_halted;
                        r_didx      <= '0;
                        r_reg_raddr <= '0;
                        r_state     <= DUMP_RD;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                DUMP_RD: begin
                    r_state <= DUMP_CAP;
                end
                DUMP_CAP: begin
                    r_out_data  <= reg_rdata;
                    r_out_valid <= 1'b1;
                    r_state     <= DUMP_OUT;
                end
                DUMP_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_didx == c_dump_last) begin
                            r_didx       <= '0;
                            r_core_reset <= 1'b1;
                            r_state      <= IDLE;
                        end else begin
                            r_didx      <= r_didx + REG_AW'(1);
                            r_reg_raddr <= r_didx + REG_AW'(1);
                            r_state     <= DUMP_RD;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = w_in_ready;
    assign imem_we    = r_imem_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;
    assign core_reset = r_core_reset;
    assign reg_raddr  = r_reg_raddr;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign busy       = (r_state != IDLE);
    assign timeout    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mips_debug_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_mips_debug_loader
// Brief  : Directed, table-driven self-checking bench for mips_debug_loader.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_mips_debug_loader;

    localparam int IMEM_AW     = 10;
    localparam int NUM_DUMP    = 6;
    localparam int RUN_TIMEOUT = 16;
    localparam int TO_W        = 16;

    logic               clk1 = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [7:0]         in_data = 8'd0;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_wdata;
    logic               core_reset;
    logic               core_halted = 1'b0;
    logic [4:0]         reg_raddr;
    logic [31:0]        reg_rdata = 32'd0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [31:0]        out_data;
    logic               busy;
    logic               timeout;

    always #5 clk1 = ~clk1;

    mips_debug_loader #(
        .IMEM_AW     (IMEM_AW),
        .NUM_DUMP    (NUM_DUMP),
        .RUN_TIMEOUT (RUN_TIMEOUT),
        .TO_W        (TO_W)
    ) dut (
        .clk1        (clk1),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .core_reset  (core_reset),
        .core_halted (core_halted),
        .reg_raddr   (reg_raddr),
        .reg_rdata   (reg_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy),
        .timeout     (timeout)
    );

    int cyc = 0;
    always @(posedge clk1) cyc <= cyc + 1;

    // Register file model: synchronous read returning 31 - address.
    always @(posedge clk1) reg_rdata <= 32'd31 - {27'd0, reg_raddr};

    // Core model: halts five cycles after release when enabled.
    bit halt_en = 1'b1;
    int run_cnt = 0;
    always @(posedge clk1) begin
        if (core_reset) begin
            run_cnt     <= 0;
            core_halted <= 1'b0;
        end else begin
            run_cnt     <= run_cnt + 1;
            core_halted <= halt_en && (run_cnt >= 4);
        end
    end

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    logic [31:0] ov_data[$];
    int          ov_cyc[$];
    int          fall_cyc = -1;
    logic        prev_cr = 1'b1;

    always @(negedge clk1) begin
        if (imem_we) begin
            wr_addr.push_back(32'(imem_addr));
            wr_data.push_back(imem_wdata);
            wr_cyc.push_back(cyc);
        end
        if (out_valid && out_ready) begin
            ov_data.push_back(out_data);
            ov_cyc.push_back(cyc);
        end
        if (prev_cr && !core_reset) fall_cyc = cyc;
        prev_cr = core_reset;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        repeat (gap) @(negedge clk1);
        @(negedge clk1);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 200) begin
            @(negedge clk1);
            n++;
        end
        if (!in_ready) check("send_stuck", 32'(in_ready), 32'd1);
        @(posedge clk1);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk1);
        while (busy && n < 2000) begin
            @(negedge clk1);
            n++;
        end
        if (busy) check("idle_wait_expired", 32'(busy), 32'd0);
    endtask

    task automatic wait_out_valid();
        int n;
        n = 0;
        @(posedge clk1);
        #1;
        while (!out_valid && n < 500) begin
            @(posedge clk1);
            #1;
            n++;
        end
        if (!out_valid) check("out_valid_wait_expired", 32'(out_valid), 32'd1);
    endtask

    task automatic check_dump(input int ob, input bool_spacing);
        check("dump_count", 32'(ov_data.size() - ob), 32'(NUM_DUMP));
        for (int k = 0; k < NUM_DUMP && (ob + k) < ov_data.size(); k++) begin
            check($sformatf("dump_word%0d", k), ov_data[ob+k], 32'(31 - k));
            if (bool_spacing != 0 && k > 0)
                check($sformatf("dump_gap%0d", k), 32'(ov_cyc[ob+k] - ov_cyc[ob+k-1]), 32'd3);
        end
    endtask

    typedef struct {
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
        bit          halt;
        bit          exp_to;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [31:0] words[2];
        int          wb;
        int          ob;

        vecs[0] = '{2, 32'h00221801, 32'hFC000000, 1'b1, 1'b0};
        vecs[1] = '{1, 32'hDEADBEEF, 32'h00000000, 1'b1, 1'b0};
        vecs[2] = '{2, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1};
        vecs[3] = '{1, 32'h00000000, 32'h00000000, 1'b1, 1'b0};

        repeat (3) @(negedge clk1);
        check("rst_core_reset", 32'(core_reset), 32'd1);
        check("rst_in_ready",   32'(in_ready),   32'd1);
        check("rst_imem_we",    32'(imem_we),    32'd0);
        check("rst_out_valid",  32'(out_valid),  32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_timeout",    32'(timeout),    32'd0);
        check("rst_imem_addr",  32'(imem_addr),  32'd0);
        check("rst_imem_wdata", imem_wdata,      32'd0);
        check("rst_out_data",   out_data,        32'd0);
        check("rst_reg_raddr",  32'(reg_raddr),  32'd0);
        rst = 1'b0;

        for (int v = 0; v < 4; v++) begin
            wb = wr_addr.size();
            ob = ov_data.size();
            halt_en = vecs[v].halt;
            words[0] = vecs[v].w0;
            words[1] = vecs[v].w1;
            send_byte(8'(vecs[v].n), 0);
            @(negedge clk1);
            check($sformatf("v%0d_timeout_cleared", v), 32'(timeout), 32'd0);
            check($sformatf("v%0d_busy_load", v), 32'(busy), 32'd1);
            for (int k = 0; k < vecs[v].n; k++)
                for (int b = 3; b >= 0; b--)
                    send_byte(words[k][8*b +: 8], 0);
            wait_idle();
            check($sformatf("v%0d_wr_count", v), 32'(wr_addr.size() - wb), 32'(vecs[v].n));
            for (int k = 0; k < vecs[v].n && (wb + k) < wr_addr.size(); k++) begin
                check($sformatf("v%0d_wr_addr%0d", v, k), wr_addr[wb+k], 32'(k));
                check($sformatf("v%0d_wr_data%0d", v, k), wr_data[wb+k], words[k]);
            end
            if (wr_cyc.size() > 0)
                check($sformatf("v%0d_release_cycle", v), 32'(fall_cyc), 32'(wr_cyc[wr_cyc.size()-1] + 1));
            check_dump(ob, 1);
            if (vecs[v].exp_to && ov_cyc.size() > ob)
                check($sformatf("v%0d_timeout_latency", v), 32'(ov_cyc[ob]), 32'(fall_cyc + RUN_TIMEOUT + 2));
            check($sformatf("v%0d_timeout", v), 32'(timeout), 32'(vecs[v].exp_to));
            check($sformatf("v%0d_core_reset_end", v), 32'(core_reset), 32'd1);
        end

        // N=0 is ignored; then a single word delivered with gaps between bytes.
        halt_en = 1'b1;
        wb = wr_addr.size();
        ob = ov_data.size();
        send_byte(8'h00, 0);
        @(negedge clk1);
        check("n0_busy", 32'(busy), 32'd0);
        check("n0_in_ready", 32'(in_ready), 32'd1);
        send_byte(8'h01, 1);
        send_byte(8'hA5, 1);
        send_byte(8'h5A, 1);
        send_byte(8'h3C, 1);
        send_byte(8'hC3, 1);
        wait_idle();
        check("gap_wr_count", 32'(wr_addr.size() - wb), 32'd1);
        if (wr_addr.size() > wb) begin
            check("gap_wr_addr", wr_addr[wb], 32'd0);
            check("gap_wr_data", wr_data[wb], 32'hA55A3CC3);
        end
        check_dump(ob, 1);

        // Backpressure: word 2 held for 10 cycles.
        ob = ov_data.size();
        out_ready = 1'b0;
        send_byte(8'h01, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        for (int k = 0; k < 2; k++) begin
            wait_out_valid();
            out_ready = 1'b1;
            @(posedge clk1);
            #1 out_ready = 1'b0;
        end
        wait_out_valid();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk1);
            check("bp_valid_held", 32'(out_valid), 32'd1);
            check("bp_data_held", out_data, 32'd29);
            check("bp_raddr_held", 32'(reg_raddr), 32'd2);
        end
        out_ready = 1'b1;
        wait_idle();
        check_dump(ob, 0);

        // Reset in the middle of a word.
        wb = wr_addr.size();
        ob = ov_data.size();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h22, 0);
        @(negedge clk1);
        rst = 1'b1;
        @(negedge clk1);
        rst = 1'b0;
        check("mid_rst_core_reset", 32'(core_reset), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk1);
        check("mid_rst_no_write", 32'(wr_addr.size() - wb), 32'd0);
        send_byte(8'h01, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        send_byte(8'hCC, 0);
        send_byte(8'hDD, 0);
        wait_idle();
        check("reload_wr_count", 32'(wr_addr.size() - wb), 32'd1);
        if (wr_addr.size() > wb) begin
            check("reload_wr_addr", wr_addr[wb], 32'd0);
            check("reload_wr_data", wr_data[wb], 32'hAABBCCDD);
        end
        check_dump(ob, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
